// File: rtl/crc5_pkg.sv
// Shared definitions for the arbitrated byte-serial CRC5 block.
// Contents: CRC5 polynomial/init constants, arbiter FSM state type and the
// byte-wide CRC5 update function (x^5+x^2+1, MSB first).
package crc5_pkg;

  localparam int unsigned CRC5_W    = 5;
  localparam logic [4:0]  CRC5_POLY = 5'h05;
  localparam logic [4:0]  CRC5_INIT = 5'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Eight serial LFSR steps, data MSB first; feedback taps come from CRC5_POLY.
  function automatic logic [CRC5_W-1:0] crc5_byte_step(input logic [CRC5_W-1:0] crc,
                                                       input logic [7:0]        data);
    logic [CRC5_W-1:0] c;
    logic              fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC5_W-1] ^ data[i];
      c  = {c[CRC5_W-2:0], 1'b0} ^ ({CRC5_W{fb}} & CRC5_POLY);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc5_byte_engine.sv
// Combinational one-byte CRC5 update; the caller owns the CRC register.
// Ports: crc (current remainder), data (byte), crc_next_c (updated remainder).
module crc5_byte_engine
  import crc5_pkg::*;
(
  input  logic [CRC5_W-1:0] crc,
  input  logic [7:0]        data,
  output logic [CRC5_W-1:0] crc_next_c
);

  assign crc_next_c = crc5_byte_step(crc, data);

endmodule

// File: rtl/crc5_arbiter.sv
// Round-robin arbiter sharing one byte-serial CRC5 engine among NREQ requesters.
// A grant covers a whole frame (valid/ready, closed by last); the result is
// returned on a single res_* port tagged with requester id and byte count.
// Ports: clk, rst (async, active-low); req_valid/req_data/req_last/req_ready per
// requester; res_valid/res_ready handshake with res_id, res_crc, res_len, res_err;
// busy (state not IDLE).
// Optional build macro CRC5_TIMEOUT_EN: abort a frame after TIMEOUT consecutive
// cycles in STREAM without an accepted byte (res_err=1, partial crc/len).
module crc5_arbiter
  import crc5_pkg::*;
#(
  parameter  int unsigned NREQ    = 2,
  parameter  int unsigned MAXLEN  = 16,
  parameter  int unsigned LEN_W   = 5,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [CRC5_W-1:0]    res_crc,
  output logic [LEN_W-1:0]     res_len,
  output logic                 res_err,
  output logic                 busy
);

  // Elaboration guard on the parameter set.
  if (NREQ < 2 || NREQ > 8 || (MAXLEN + 1) >= (1 << LEN_W) || TIMEOUT == 0) begin : g_bad_params
    $error("crc5_arbiter: illegal parameter set");
  end

  state_t            state, state_d;
  logic [ID_W-1:0]   grant, grant_d, ptr, ptr_d;
  logic [CRC5_W-1:0] crc, crc_d;
  logic [LEN_W-1:0]  len, len_d;
  logic              err, err_d;
  logic [NREQ-1:0]   req_ready_d;
  logic              res_valid_d, res_err_d, busy_d;
  logic [ID_W-1:0]   res_id_d;
  logic [CRC5_W-1:0] res_crc_d;
  logic [LEN_W-1:0]  res_len_d;

  logic [7:0]        data_arr [NREQ];
  logic [7:0]        byte_c;
  logic              accept_c, last_c, len_full_c, found_c;
  logic [LEN_W-1:0]  len_inc_c;
  logic [ID_W-1:0]   pick_c, idx_c;
  logic [CRC5_W-1:0] crc_next_c;

`ifdef CRC5_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall, stall_d;
`endif

  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign data_arr[k] = req_data[8*k +: 8];
  end

  // req_ready is one-hot at the grant in STREAM only, so this is the grantee's handshake.
  assign accept_c   = |(req_valid & req_ready);
  assign byte_c     = data_arr[grant];
  assign last_c     = req_last[grant];
  assign len_full_c = (len == LEN_W'(MAXLEN));
  assign len_inc_c  = (len == LEN_W'(MAXLEN + 1)) ? len : len + LEN_W'(1);

  crc5_byte_engine u_engine (
    .crc        (crc),
    .data       (byte_c),
    .crc_next_c (crc_next_c)
  );

  // First valid requester at or after the pointer, wrapping.
  always_comb begin : p_pick
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx_c = ID_W'((int'(ptr) + i) % int'(NREQ));
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin : p_next
    state_d     = state;
    grant_d     = grant;
    ptr_d       = ptr;
    crc_d       = crc;
    len_d       = len;
    err_d       = err;
    req_ready_d = req_ready;
    res_valid_d = res_valid;
    res_id_d    = res_id;
    res_crc_d   = res_crc;
    res_len_d   = res_len;
    res_err_d   = res_err;
`ifdef CRC5_TIMEOUT_EN
    stall_d     = stall;
`endif
    unique case (state)
      IDLE: begin
        req_ready_d = '0;
        if (found_c) begin
          grant_d     = pick_c;
          crc_d       = CRC5_INIT;
          len_d       = '0;
          err_d       = 1'b0;
          req_ready_d = NREQ'(1) << pick_c;
`ifdef CRC5_TIMEOUT_EN
          stall_d     = '0;
`endif
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (accept_c) begin
          crc_d = crc_next_c;
          len_d = len_inc_c;
          err_d = err | len_full_c;
          if (last_c) begin
            res_valid_d = 1'b1;
            res_id_d    = grant;
            res_crc_d   = crc_next_c;
            res_len_d   = len_inc_c;
            res_err_d   = err | len_full_c;
            req_ready_d = '0;
            state_d     = RESULT;
          end
        end
`ifdef CRC5_TIMEOUT_EN
        stall_d = accept_c ? '0 : stall + TO_W'(1);
        // TIMEOUT-th consecutive empty cycle: close the frame with partial values.
        if (!accept_c && stall == TO_W'(TIMEOUT - 1)) begin
          res_valid_d = 1'b1;
          res_id_d    = grant;
          res_crc_d   = crc;
          res_len_d   = len;
          res_err_d   = 1'b1;
          req_ready_d = '0;
          state_d     = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        req_ready_d = '0;
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin : p_regs
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      crc       <= CRC5_INIT;
      len       <= '0;
      err       <= 1'b0;
      req_ready <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_crc   <= '0;
      res_len   <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef CRC5_TIMEOUT_EN
      stall     <= '0;
`endif
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      ptr       <= ptr_d;
      crc       <= crc_d;
      len       <= len_d;
      err       <= err_d;
      req_ready <= req_ready_d;
      res_valid <= res_valid_d;
      res_id    <= res_id_d;
      res_crc   <= res_crc_d;
      res_len   <= res_len_d;
      res_err   <= res_err_d;
      busy      <= busy_d;
`ifdef CRC5_TIMEOUT_EN
      stall     <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_crc5_arbiter.sv
// Self-checking bench for crc5_arbiter: a frame-level reference model (CRC by
// polynomial long division of the whole frame) checked every cycle, plus
// hand-computed literal expectations for the directed frames.
// With CRC5_TIMEOUT_EN defined, TIMEOUT is 8 and the stall-abort case runs too.
module tb_crc5_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned MAXLEN = 16;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned ID_W   = 1;
`ifdef CRC5_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [8*NREQ-1:0]  req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [ID_W-1:0]    res_id;
  logic [4:0]         res_crc;
  logic [LEN_W-1:0]   res_len;
  logic               res_err;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  crc5_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_crc(res_crc),
    .res_len(res_len), .res_err(res_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int               m_owner;
  int               m_ptr;
  int               m_cnt;
  int               m_stall;
  bit               m_pend;
  logic [7:0]       m_buf [64];
  logic [ID_W-1:0]  m_res_id;
  logic [4:0]       m_res_crc;
  logic [LEN_W-1:0] m_res_len;
  bit               m_res_err;
  logic [NREQ-1:0]  exp_ready;

  // Remainder of frame(x)*x^5 divided by x^5+x^2+1.
  function automatic logic [4:0] model_crc();
    logic [5:0] rem;
    logic       b;
    int         nb;
    rem = '0;
    nb  = ((m_cnt < 64) ? m_cnt : 64) * 8;
    for (int i = 0; i < nb + 5; i++) begin
      b = 1'b0;
      if (i < nb) b = m_buf[i / 8][7 - (i % 8)];
      rem = {rem[4:0], b};
      if (rem[5]) rem = rem ^ 6'b100101;
    end
    return rem[4:0];
  endfunction

  task automatic model_finish(input bit abort);
    m_res_id  = ID_W'(m_owner);
    m_res_crc = model_crc();
    m_res_len = (m_cnt > int'(MAXLEN)) ? LEN_W'(MAXLEN + 1) : LEN_W'(m_cnt);
    m_res_err = abort || (m_cnt > int'(MAXLEN));
    m_pend    = 1'b1;
    m_owner   = -1;
  endtask

  initial begin
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0; m_pend = 1'b0;
    m_res_id = '0; m_res_crc = '0; m_res_len = '0; m_res_err = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0; m_pend = 1'b0;
      end else if (m_pend) begin
        if (res_ready) begin
          m_pend = 1'b0;
          m_ptr  = (int'(m_res_id) + 1) % int'(NREQ);
        end
      end else if (m_owner >= 0) begin
        if (req_valid[m_owner]) begin
          if (m_cnt < 64) m_buf[m_cnt] = req_data[8*m_owner +: 8];
          m_cnt++;
          m_stall = 0;
          if (req_last[m_owner]) model_finish(1'b0);
        end else begin
          m_stall++;
`ifdef CRC5_TIMEOUT_EN
          if (m_stall == int'(TO)) model_finish(1'b1);
`endif
        end
      end else begin
        for (int i = 0; i < int'(NREQ); i++)
          if (m_owner < 0 && req_valid[(m_ptr + i) % int'(NREQ)]) m_owner = (m_ptr + i) % int'(NREQ);
        m_cnt   = 0;
        m_stall = 0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_ready = '0;
        if (m_owner >= 0) exp_ready[m_owner] = 1'b1;
        check("cyc_req_ready", req_ready, exp_ready);
        check("cyc_onehot", ($countones(req_ready) <= 1), 1);
        check("cyc_res_valid", res_valid, m_pend);
        check("cyc_busy", busy, (m_owner >= 0) || m_pend);
        if (m_pend) begin
          check("cyc_res_id", res_id, m_res_id);
          check("cyc_res_crc", res_crc, m_res_crc);
          check("cyc_res_len", res_len, m_res_len);
          check("cyc_res_err", res_err, m_res_err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] fbuf [32];

  task automatic wait_accept(input int id);
    int t;
    t = 0;
    while (!req_ready[id] && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[id]) check("accept_timeout", req_ready[id], 1);
    @(negedge clk);
  endtask

  task automatic send_frame(input int id, input int n, input int gap, input bit close);
    for (int b = 0; b < n; b++) begin
      req_data[8*id +: 8] = fbuf[b];
      req_valid[id]       = 1'b1;
      req_last[id]        = close && (b == n - 1);
      wait_accept(id);
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      if (b < n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic expect_result(input string name, input int id, input int crc, input int len,
                               input int err, input bit chk_crc, output int waited);
    waited = 0;
    while (!res_valid && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!res_valid) begin
      check({name, "_valid"}, res_valid, 1);
    end else begin
      check({name, "_id"}, res_id, id);
      check({name, "_len"}, res_len, len);
      check({name, "_err"}, res_err, err);
      if (chk_crc) check({name, "_crc"}, res_crc, crc);
    end
    @(negedge clk);
  endtask

  initial begin
    int ids [4];
    int n, budget, waited;
    bit held;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_crc", res_crc, 0);
    check("rst_res_len", res_len, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single byte 0x01 from req 0: ready in cycle 1, result in cycle 2.
    req_data[7:0] = 8'h01; req_valid = 2'b01; req_last = 2'b01;
    @(negedge clk);
    check("t1_ready_c1", req_ready, 2'b01);
    check("t1_valid_c1", res_valid, 0);
    @(negedge clk);
    check("t1_valid_c2", res_valid, 1);
    check("t1_crc", res_crc, 5'h05);
    check("t1_len", res_len, 1);
    check("t1_id", res_id, 0);
    check("t1_err", res_err, 0);
    req_valid = '0; req_last = '0;
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Single byte 0xFF from req 1.
    fbuf[0] = 8'hFF;
    send_frame(1, 1, 0, 1'b1);
    expect_result("t2", 1, 5'h14, 1, 0, 1'b1, waited);

    // Both requesters always valid with 1-byte frames: grants alternate.
    for (int k = 0; k < 4; k++) ids[k] = 9;
    req_data = {8'hFF, 8'h01}; req_last = 2'b11; req_valid = 2'b11;
    n = 0; budget = 0; held = 1'b0;
    while (n < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (res_valid) begin
        if (n == 2 && !held) begin
          held = 1'b1;
          res_ready = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_id", res_id, 0);
            check("hold_crc", res_crc, 5'h05);
            check("hold_len", res_len, 1);
          end
          res_ready = 1'b1;
        end
        ids[n] = int'(res_id);
        n++;
        if (n == 4) begin
          req_valid = '0;
          req_last  = '0;
        end
      end
    end
    check("alt_count", n, 4);
    for (int k = 0; k < 4; k++) check("alt_id", ids[k], k % 2);
    @(negedge clk);

    // Two bytes with a 3-cycle bubble between them.
    fbuf[0] = 8'h01; fbuf[1] = 8'h00;
    send_frame(0, 2, 3, 1'b1);
    expect_result("t3", 0, 5'h1C, 2, 0, 1'b1, waited);

    // Overlong frame, then a normal one.
    for (int k = 0; k < 18; k++) fbuf[k] = 8'(k * 7 + 3);
    send_frame(0, 18, 0, 1'b1);
    expect_result("t5_long", 0, 0, 17, 1, 1'b0, waited);
    fbuf[0] = 8'h01;
    send_frame(0, 1, 0, 1'b1);
    expect_result("t5_after", 0, 5'h05, 1, 0, 1'b1, waited);

    // Asynchronous reset mid-frame after 3 bytes.
    fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC;
    send_frame(0, 3, 0, 1'b0);
    check("t6_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_req_ready", req_ready, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_id", res_id, 0);
    check("t6_res_crc", res_crc, 0);
    check("t6_res_len", res_len, 0);
    check("t6_res_err", res_err, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fbuf[0] = 8'hFF;
    send_frame(1, 1, 0, 1'b1);
    expect_result("t6_fresh", 1, 5'h14, 1, 0, 1'b1, waited);

`ifdef CRC5_TIMEOUT_EN
    // One byte then stall: abort after 8 empty cycles.
    fbuf[0] = 8'hFF;
    send_frame(0, 1, 0, 1'b0);
    expect_result("t7_timeout", 0, 5'h14, 1, 1, 1'b1, waited);
    check("t7_wait", waited, 8);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc5_arbiter.md
Name: crc5_arbiter

Overview:
- Shares one byte-serial CRC5 engine between NREQ requesters.
  - Polynomial x^5+x^2+1, init 5'b0, MSB-first, one byte per cycle.
- Round-robin arbitration grants the engine for a whole frame. A frame is streamed with a valid/ready handshake and closed by a last flag.
- The CRC result is returned on a single result port tagged with the requester id and the byte count.
- Sits between packet builders (token/handshake generators) and the link framer.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAXLEN, 16, maximum bytes per frame; longer frames are flagged as errors.
- LEN_W, 5, width of the byte counter and res_len; must hold MAXLEN+1.
- TIMEOUT, 64, idle-stall limit in cycles; used only with CRC5_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last  in  NREQ  marks the final byte of a frame.
- req_ready  out  NREQ  byte accepted when valid&ready; one-hot or zero.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  $clog2(NREQ) (min 1)  requester that owned the frame.
- res_crc  out  5  CRC5 of the frame.
- res_len  out  LEN_W  bytes accepted, saturating at MAXLEN+1.
- res_err  out  1  length overflow, or timeout abort when enabled.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, req_ready=0, res_valid=0, res_id=0, res_crc=0, res_len=0, res_err=0, busy=0. The round-robin pointer resets to 0, so requester 0 has the highest priority first.
- FSM states: IDLE, STREAM, RESULT.
- IDLE:
  - If any req_valid is high, register a grant to the first valid requester at or after the pointer, wrapping.
  - Clear crc, len and err, then go to STREAM.
  - req_ready stays 0 in IDLE.
- STREAM:
  - req_ready[g]=1 only for the granted requester g.
  - Each accepted byte: crc <= step(crc, byte); len <= sat(len+1).
  - If len already equals MAXLEN when a byte is accepted, set err. The byte is still absorbed into crc and len saturates at MAXLEN+1.
  - The accepted byte with req_last=1 causes the next state to be RESULT. res_crc, res_len, res_id and res_err are registered in that same edge.
  - Requests from other requesters are ignored until RESULT completes. There is no preemption.
  - A bubble (req_valid[g]=0) only stalls; CRC state is held.
- RESULT:
  - res_valid=1 and all res_* outputs stay stable until res_valid&res_ready.
  - On handshake: pointer <= g+1 mod NREQ, then go to IDLE.
  - res_ready is ignored when res_valid=0.
- Latency: a 1-byte frame presented in cycle 0 (IDLE) is accepted in cycle 1, and res_valid is high in cycle 2. An N-byte frame with no bubbles gives res_valid in cycle N+1.
- Throughput: with res_ready tied high, RESULT lasts one cycle, so consecutive frames have a 2-cycle gap (RESULT, IDLE).
- A requester withdrawing valid in IDLE before the grant registers is legal. Grant selection uses the sampled req_valid only.
- Reset mid-frame aborts immediately; no result is produced and the pointer returns to 0.
- Arithmetic:
  - step() applies 8 shift iterations, MSB first: fb=c[4]^d; c={c[3],c[2],c[1]^fb,c[0],fb}.
  - len saturates and never wraps.

Optional Feature:
- Macro CRC5_TIMEOUT_EN.
- Defined: a stall counter in STREAM counts consecutive cycles without an accepted byte.
  - Reaching TIMEOUT aborts the frame and goes to RESULT with res_err=1. res_crc and res_len hold the partial values.
  - The counter clears on each accepted byte and on entry to STREAM.
- Undefined: no counter; STREAM waits indefinitely for the granted requester. Behaviour is otherwise identical.

Decomposition:
- Package crc5_pkg:
  - CRC5_POLY=5'h05 and CRC5_INIT=5'h00.
  - State enum type (IDLE/STREAM/RESULT).
  - Function crc5_byte_step(crc, data).
- One sub-module, crc5_byte_engine: purely combinational byte update wrapping crc5_byte_step. The arbiter instantiates it once and holds the CRC register itself.

Test Plan:
- Single byte 0x01 from req 0, res_ready=1 -> res_valid in cycle 2, res_crc=5'h05, res_len=1, res_id=0, res_err=0.
- Single byte 0xFF from req 1 -> res_crc=5'h14, res_len=1, res_id=1.
- Two-byte frame {0x01,0x00} from req 0, with a 3-cycle valid bubble between bytes -> res_crc=5'h1C, res_len=2, CRC unchanged during the bubble.
- Both requesters continuously valid, each sending 1-byte frames:
  - grants alternate 0,1,0,1;
  - req_ready never high for both;
  - res_valid held with res_ready=0 for 4 cycles keeps outputs stable.
- Frame of MAXLEN+2=18 bytes -> res_err=1, res_len=17; a following 1-byte frame has res_err=0.
- Assert rst mid-frame after 3 bytes -> all outputs return to reset values asynchronously; the next frame from req 1 yields a correct fresh CRC.
- With CRC5_TIMEOUT_EN defined and TIMEOUT=8: grant req 0, send 1 byte, then stall -> RESULT after 8 idle cycles with res_err=1, res_len=1, res_crc=step(0, that byte).
